// File: rtl/wb_pkg.sv
// Shared types and default widths for the posted-write buffer.
package wb_pkg;

    localparam int WB_AW    = 32;
    localparam int WB_DW    = 32;
    localparam int WB_DEPTH = 4;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_REQ  = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular store queue with occupancy counter; also exposes every
// slot in age order (index 0 = oldest) so the owner can run an associative lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = WB_DEPTH,
    parameter type entry_t = wb_entry_t,
    parameter int  CW      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  entry_t                push_entry,
    input  logic                  pop,
    output entry_t                head,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         count_next,
    output logic [DEPTH-1:0]      entry_valid,
    output entry_t [DEPTH-1:0]    entries
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count <= count_next;
        end
    end

    // NOTE: storage carries no reset; an entry is only meaningful while count covers it.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_entry;
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    assign head = mem[rptr];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries[k]     = mem[rptr + PW'(k)];
            entry_valid[k] = (CW'(k) < count);
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Posted-write buffer: FIFO of cache stores drained to RAM by a req/ack engine,
// with a combinational pending-store lookup. Define WB_FORWARD_EN to forward lk_data.
module write_buffer
    import wb_pkg::*;
#(
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    parameter int DEPTH = WB_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] lk_addr,
    output logic          lk_match,
    output logic [DW-1:0] lk_data,
    output logic          ram_req,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic          ram_ack,
    output logic [CW-1:0] count,
    output logic          empty
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    wb_state_t            state;
    logic                 push;
    logic                 pop;
    entry_t               push_entry;
    entry_t               head;
    logic [CW-1:0]        count_next;
    logic [DEPTH-1:0]     entry_valid;
    entry_t [DEPTH-1:0]   entries;

    // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign wr_ready   = !rst && (count != CW'(DEPTH));
    assign push       = wr_valid && wr_ready;
    assign pop        = (state == WB_REQ) && ram_ack;
    assign push_entry = '{addr: wr_addr, data: wr_data};
    assign empty      = (count == '0);

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t),
        .CW      (CW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .count_next  (count_next),
        .entry_valid (entry_valid),
        .entries     (entries)
    );

    // Leaving IDLE on count_next lets a store pushed at edge N be requested in cycle N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_IDLE;
        end else begin
            unique case (state)
                WB_IDLE: if (count_next != '0) state <= WB_REQ;
                WB_REQ:  if (pop && count_next == '0) state <= WB_IDLE;
                default: state <= WB_IDLE;
            endcase
        end
    end

    assign ram_req   = (state == WB_REQ);
    assign ram_addr  = ram_req ? head.addr : '0;
    assign ram_wdata = ram_req ? head.data : '0;

`ifdef WB_FORWARD_EN
    // Scan oldest to newest so the newest hit overwrites older ones.
    always_comb begin
        // NOTE: defaults first so no path through the loop can infer a latch.
        lk_match = 1'b0;
        lk_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!rst && entry_valid[k] && entries[k].addr == lk_addr) begin
                lk_match = 1'b1;
                lk_data  = entries[k].data;
            end
        end
    end
`else
    always_comb begin
        lk_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!rst && entry_valid[k] && entries[k].addr == lk_addr) lk_match = 1'b1;
        end
    end

    assign lk_data = '0;
`endif

endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer (default DEPTH=4, 32-bit paths).
module tb_write_buffer;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef WB_FORWARD_EN
    localparam logic [DW-1:0] FWD_ONE = 32'd1;
    localparam logic [DW-1:0] FWD_TWO = 32'd2;
`else
    localparam logic [DW-1:0] FWD_ONE = 32'd0;
    localparam logic [DW-1:0] FWD_TWO = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] lk_addr;
    logic          lk_match;
    logic [DW-1:0] lk_data;
    logic          ram_req;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ack;
    logic [CW-1:0] count;
    logic          empty;

    int checks   = 0;
    int failures = 0;

    write_buffer #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .lk_addr   (lk_addr),
        .lk_match  (lk_match),
        .lk_data   (lk_data),
        .ram_req   (ram_req),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_ack   (ram_ack),
        .count     (count),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; inputs set before the call take effect at that edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        lk_addr  = '0;
        ram_ack  = 1'b0;
        cyc();
        cyc();

        // Reset state
        check("rst_ram_req",   64'(ram_req),   64'd0);
        check("rst_ram_addr",  64'(ram_addr),  64'd0);
        check("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        check("rst_lk_match",  64'(lk_match),  64'd0);
        check("rst_lk_data",   64'(lk_data),   64'd0);
        check("rst_empty",     64'(empty),     64'd1);
        check("rst_count",     64'(count),     64'd0);
        check("rst_wr_ready",  64'(wr_ready),  64'd0);
        rst = 1'b0;
        settle();
        check("post_rst_wr_ready", 64'(wr_ready), 64'd1);

        // Single store, fast RAM
        wr_valid = 1'b1;
        wr_addr  = 32'h10;
        wr_data  = 32'hAAAA;
        ram_ack  = 1'b1;
        cyc();
        wr_valid = 1'b0;
        settle();
        check("single_req",   64'(ram_req),   64'd1);
        check("single_addr",  64'(ram_addr),  64'h10);
        check("single_wdata", 64'(ram_wdata), 64'hAAAA);
        check("single_count", 64'(count),     64'd1);
        cyc();
        check("single_empty", 64'(empty),   64'd1);
        check("single_idle",  64'(ram_req), 64'd0);
        ram_ack = 1'b0;

        // Full / backpressure
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = AW'(i);
            wr_data  = DW'(32'h100 + i);
            cyc();
        end
        wr_addr = 32'h4;
        wr_data = 32'h104;
        settle();
        check("full_count",    64'(count),    64'd4);
        check("full_wr_ready", 64'(wr_ready), 64'd0);
        check("full_req",      64'(ram_req),  64'd1);
        check("full_head",     64'(ram_addr), 64'h0);
        cyc();
        check("full_held_count", 64'(count), 64'd4);
        ram_ack = 1'b1;
        cyc();
        ram_ack = 1'b0;
        settle();
        check("after_ack_wr_ready", 64'(wr_ready), 64'd1);
        check("after_ack_count",    64'(count),    64'd3);
        check("after_ack_head",     64'(ram_addr), 64'h1);
        cyc();
        wr_valid = 1'b0;
        settle();
        check("fifth_accepted_count", 64'(count), 64'd4);
        ram_ack = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            settle();
            check($sformatf("order_addr_%0d", k),  64'(ram_addr),  64'(k));
            check($sformatf("order_wdata_%0d", k), 64'(ram_wdata), 64'(32'h100 + k));
            cyc();
        end
        check("order_empty", 64'(empty),   64'd1);
        check("order_idle",  64'(ram_req), 64'd0);
        ram_ack = 1'b0;

        // Forwarding
        lk_addr  = 32'h20;
        wr_valid = 1'b1;
        wr_addr  = 32'h20;
        wr_data  = 32'd1;
        settle();
        check("fwd_not_yet_visible", 64'(lk_match), 64'd0);
        cyc();
        wr_data = 32'd2;
        settle();
        check("fwd_one_match", 64'(lk_match), 64'd1);
        check("fwd_one_data",  64'(lk_data),  64'(FWD_ONE));
        cyc();
        wr_valid = 1'b0;
        settle();
        check("fwd_two_match",  64'(lk_match), 64'd1);
        check("fwd_newest",     64'(lk_data),  64'(FWD_TWO));
        lk_addr = 32'h24;
        settle();
        check("fwd_miss_match", 64'(lk_match), 64'd0);
        check("fwd_miss_data",  64'(lk_data),  64'd0);
        lk_addr = 32'h20;
        ram_ack = 1'b1;
        settle();
        check("fwd_acked_still_valid", 64'(lk_match), 64'd1);
        cyc();
        check("fwd_after_pop_count", 64'(count),   64'd1);
        check("fwd_after_pop_data",  64'(lk_data), 64'(FWD_TWO));
        cyc();
        ram_ack = 1'b0;
        settle();
        check("fwd_drained_empty", 64'(empty),    64'd1);
        check("fwd_drained_match", 64'(lk_match), 64'd0);

        // Streaming with wrap-around
        ram_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_addr  = AW'(32'h40 + i);
            wr_data  = DW'(32'h500 + i);
            cyc();
            check($sformatf("stream_req_%0d", i),   64'(ram_req),   64'd1);
            check($sformatf("stream_addr_%0d", i),  64'(ram_addr),  64'(32'h40 + i));
            check($sformatf("stream_wdata_%0d", i), 64'(ram_wdata), 64'(32'h500 + i));
            check($sformatf("stream_count_%0d", i), 64'(count),     64'd1);
        end
        wr_valid = 1'b0;
        cyc();
        check("stream_end_empty", 64'(empty),   64'd1);
        check("stream_end_idle",  64'(ram_req), 64'd0);
        ram_ack = 1'b0;

        // Reset mid-drain
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr  = AW'(32'h60 + i);
            wr_data  = DW'(32'h600 + i);
            cyc();
        end
        wr_valid = 1'b0;
        lk_addr  = 32'h61;
        settle();
        check("mid_count", 64'(count),    64'd3);
        check("mid_req",   64'(ram_req),  64'd1);
        check("mid_match", 64'(lk_match), 64'd1);
        rst = 1'b1;
        settle();
        check("mid_rst_wr_ready", 64'(wr_ready), 64'd0);
        cyc();
        rst = 1'b0;
        settle();
        check("mid_after_req",      64'(ram_req),  64'd0);
        check("mid_after_count",    64'(count),    64'd0);
        check("mid_after_empty",    64'(empty),    64'd1);
        check("mid_after_match",    64'(lk_match), 64'd0);
        check("mid_after_wr_ready", 64'(wr_ready), 64'd1);
        check("mid_after_addr",     64'(ram_addr), 64'd0);

        // Stray ack on an empty buffer
        ram_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("stray_count_%0d", i), 64'(count),   64'd0);
            check($sformatf("stray_req_%0d", i),   64'(ram_req), 64'd0);
        end
        ram_ack  = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 32'h70;
        wr_data  = 32'h77;
        cyc();
        wr_valid = 1'b0;
        settle();
        check("stray_then_req",   64'(ram_req),   64'd1);
        check("stray_then_addr",  64'(ram_addr),  64'h70);
        check("stray_then_wdata", 64'(ram_wdata), 64'h77);
        check("stray_then_count", 64'(count),     64'd1);
        ram_ack = 1'b1;
        cyc();
        ram_ack = 1'b0;
        check("stray_final_empty", 64'(empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
